rr_grant_arbiter: RTL and testbench



---
 rtl/rr_grant_arbiter.sv | 126 ++++++++++++
 tb/tb_rr_grant_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter.sv
// Registered round-robin arbiter with a valid/ready grant handshake.
// The winner is held while downstream stalls. After every accepted grant,
// priority rotates to the requester just past the one that was served.
module rr_grant_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               flush,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0]   grant_idx
);

    // One extra bit so that grant_idx+1 cannot overflow before the wrap test.
    localparam int PW = IDX_W + 1;

    logic               out_valid_q, out_valid_d;
    logic [NUM_REQ-1:0] grant_oh_q,  grant_oh_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]   ptr_q,       ptr_d;

    logic               fire;
    logic               load;
    logic [PW-1:0]      idxInc;
    logic [IDX_W-1:0]   idxNext;
    logic [IDX_W-1:0]   effPtr;
    logic [NUM_REQ-1:0] mreq;
    logic [NUM_REQ-1:0] hiMask;
    logic [NUM_REQ-1:0] hiReq;
    logic [NUM_REQ-1:0] pickSrc;
    logic [NUM_REQ-1:0] winOh;
    logic [IDX_W-1:0]   winIdx;

    assign fire = out_valid_q & out_ready;
    assign load = ~out_valid_q | out_ready;

    // Index after the current grant, wrapped at NUM_REQ (NUM_REQ need not be a power of two).
    always_comb begin
        idxInc  = PW'(grant_idx_q) + PW'(1);
        idxNext = idxInc[IDX_W-1:0];
        if (idxInc == PW'(NUM_REQ)) begin
            idxNext = '0;
        end
    end

    // Effective start point and masked requests; the grant just accepted sits out one cycle.
    always_comb begin
        effPtr = ptr_q;
        mreq   = req;
        if (fire) begin
            effPtr = idxNext;
            mreq   = req & ~grant_oh_q;
        end
    end

    // Circular scan done as two linear scans: requests at or above effPtr win first,
    // otherwise the lowest request overall wins.
    always_comb begin
        hiMask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hiMask[i] = (PW'(i) >= {1'b0, effPtr});
        end
        hiReq   = mreq & hiMask;
        pickSrc = (|hiReq) ? hiReq : mreq;
        winOh   = pickSrc & (-pickSrc);
    end

    // One-hot to binary: each index bit is the OR of the one-hot bits whose position has that bit set.
    always_comb begin
        winIdx = '0;
        for (int b = 0; b < IDX_W; b++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (((i >> b) & 1) == 1) begin
                    winIdx[b] = winIdx[b] | winOh[i];
                end
            end
        end
    end

    // Next-state selection: flush beats everything, then load a fresh result, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        grant_oh_d  = grant_oh_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        if (flush) begin
            out_valid_d = 1'b0;
            grant_oh_d  = '0;
            grant_idx_d = '0;
            ptr_d       = '0;
        end else begin
            if (fire) begin
                ptr_d = idxNext;
            end
            if (load) begin
                out_valid_d = |mreq;
                grant_oh_d  = winOh;
                grant_idx_d = winIdx;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            grant_oh_q  <= '0;
            grant_idx_q <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            grant_oh_q  <= grant_oh_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign grant_oh  = grant_oh_q;
    assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Testbench for rr_grant_arbiter. It drives a 4-requester and a 3-requester
// instance and checks both against a round-robin reference model.
module tb_rr_grant_arbiter;

    logic       clk;
    logic       rst_n;

    logic [3:0] req4;
    logic       flush4, ready4, valid4;
    logic [3:0] oh4;
    logic [1:0] idx4;

    logic [2:0] req3;
    logic       flush3, ready3, valid3;
    logic [2:0] oh3;
    logic [1:0] idx3;

    int testsRun    = 0;
    int testsFailed = 0;

    bit mV4, mV3;
    int mI4, mI3, mP4, mP3;

    rr_grant_arbiter #(.NUM_REQ(4), .IDX_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .flush(flush4), .out_ready(ready4),
        .out_valid(valid4), .grant_oh(oh4), .grant_idx(idx4)
    );

    rr_grant_arbiter #(.NUM_REQ(3), .IDX_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .flush(flush3), .out_ready(ready3),
        .out_valid(valid3), .grant_oh(oh3), .grant_idx(idx3)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arbiter: circular search from the priority index using modular arithmetic.
    function automatic void modelStep(input int n, input logic [7:0] rq, input logic fl,
                                      input logic rdy, inout bit v, inout int idx, inout int ptr);
        bit         fire;
        bit         found;
        int         start;
        int         win;
        logic [7:0] m;
        if (fl) begin
            v = 1'b0; idx = 0; ptr = 0;
            return;
        end
        if (v && !rdy) return;
        fire = v && rdy;
        m    = rq;
        if (fire) begin
            ptr = (idx + 1) % n;
            m   = rq & ~(8'd1 << idx);
        end
        start = ptr;
        found = 1'b0;
        win   = 0;
        for (int k = 0; k < n; k++) begin
            int pos;
            pos = (start + k) % n;
            if (!found && m[pos]) begin
                found = 1'b1;
                win   = pos;
            end
        end
        v   = found;
        idx = found ? win : 0;
    endfunction

    function automatic logic [7:0] ohOf(input bit v, input int idx);
        return v ? (8'd1 << idx) : 8'd0;
    endfunction

    task automatic resetModels();
        mV4 = 1'b0; mI4 = 0; mP4 = 0;
        mV3 = 1'b0; mI3 = 0; mP3 = 0;
    endtask

    // Advance one clock edge, step the reference models and settle away from the edge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            resetModels();
        end else begin
            modelStep(4, {4'b0, req4}, flush4, ready4, mV4, mI4, mP4);
            modelStep(3, {5'b0, req3}, flush3, ready3, mV3, mI3, mP3);
        end
        #1;
    endtask

    task automatic idle4();
        req4 = 4'b0; ready4 = 1'b1; flush4 = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        testsRun++;
        if ({valid4, oh4, idx4} !== 7'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset4: got v=%b oh=%b idx=%0d, want all zero", valid4, oh4, idx4);
        end
        testsRun++;
        if ({valid3, oh3, idx3} !== 6'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset3: got v=%b oh=%b idx=%0d, want all zero", valid3, oh3, idx3);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_full_contention();
        int         expSeq [6];
        logic [3:0] eOh;
        expSeq = '{0, 1, 2, 3, 0, 1};
        req4 = 4'b1111; ready4 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            eOh = 4'b0001 << expSeq[k];
            testsRun++;
            if ({valid4, oh4, idx4} !== {1'b1, eOh, 2'(expSeq[k])}) begin
                testsFailed++;
                $display("[TB] FAIL contention[%0d]: got v=%b oh=%b idx=%0d, want v=1 oh=%b idx=%0d",
                         k, valid4, oh4, idx4, eOh, expSeq[k]);
            end
        end
        idle4();
    endtask

    task automatic test_backpressure();
        req4 = 4'b0100; ready4 = 1'b0;
        step();
        testsRun++;
        if ({valid4, oh4, idx4} !== {1'b1, 4'b0100, 2'd2}) begin
            testsFailed++;
            $display("[TB] FAIL bp_first: got v=%b oh=%b idx=%0d, want v=1 oh=0100 idx=2", valid4, oh4, idx4);
        end
        req4 = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            step();
            testsRun++;
            if ({valid4, oh4, idx4} !== {1'b1, 4'b0100, 2'd2}) begin
                testsFailed++;
                $display("[TB] FAIL bp_hold[%0d]: got v=%b oh=%b idx=%0d, want v=1 oh=0100 idx=2",
                         k, valid4, oh4, idx4);
            end
        end
        ready4 = 1'b1;
        step();
        testsRun++;
        if ({valid4, oh4, idx4} !== {1'b1, 4'b0001, 2'd0}) begin
            testsFailed++;
            $display("[TB] FAIL bp_release: got v=%b oh=%b idx=%0d, want v=1 oh=0001 idx=0", valid4, oh4, idx4);
        end
        idle4();
    endtask

    task automatic test_single_requester();
        logic       eV;
        logic [3:0] eOh;
        logic [1:0] eIdx;
        req4 = 4'b0100; ready4 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            eV   = ((k % 2) == 0);
            eOh  = eV ? 4'b0100 : 4'b0000;
            eIdx = eV ? 2'd2 : 2'd0;
            testsRun++;
            if ({valid4, oh4, idx4} !== {eV, eOh, eIdx}) begin
                testsFailed++;
                $display("[TB] FAIL single[%0d]: got v=%b oh=%b idx=%0d, want v=%b oh=%b idx=%0d",
                         k, valid4, oh4, idx4, eV, eOh, eIdx);
            end
        end
        idle4();
    endtask

    task automatic test_non_pow2();
        int         expSeq [5];
        logic [2:0] eOh;
        expSeq = '{0, 1, 2, 0, 1};
        flush3 = 1'b1; ready3 = 1'b1; req3 = 3'b000;
        step();
        flush3 = 1'b0; req3 = 3'b111;
        for (int k = 0; k < 5; k++) begin
            step();
            eOh = 3'b001 << expSeq[k];
            testsRun++;
            if ({valid3, oh3, idx3} !== {1'b1, eOh, 2'(expSeq[k])}) begin
                testsFailed++;
                $display("[TB] FAIL npow2[%0d]: got v=%b oh=%b idx=%0d, want v=1 oh=%b idx=%0d",
                         k, valid3, oh3, idx3, eOh, expSeq[k]);
            end
        end
        req3 = 3'b000;
        step();
        step();
    endtask

    task automatic test_flush_hold();
        req4 = 4'b1000; ready4 = 1'b0;
        step();
        testsRun++;
        if ({valid4, oh4, idx4} !== {1'b1, 4'b1000, 2'd3}) begin
            testsFailed++;
            $display("[TB] FAIL flush_pre: got v=%b oh=%b idx=%0d, want v=1 oh=1000 idx=3", valid4, oh4, idx4);
        end
        flush4 = 1'b1; req4 = 4'b1001;
        step();
        testsRun++;
        if ({valid4, oh4, idx4} !== 7'b0) begin
            testsFailed++;
            $display("[TB] FAIL flush_clear: got v=%b oh=%b idx=%0d, want all zero", valid4, oh4, idx4);
        end
        flush4 = 1'b0;
        step();
        testsRun++;
        if ({valid4, oh4, idx4} !== {1'b1, 4'b0001, 2'd0}) begin
            testsFailed++;
            $display("[TB] FAIL flush_resume: got v=%b oh=%b idx=%0d, want v=1 oh=0001 idx=0", valid4, oh4, idx4);
        end
        idle4();
    endtask

    task automatic test_async_reset();
        req4 = 4'b1111; ready4 = 1'b0;
        step();
        testsRun++;
        if (valid4 !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL areset_pre: got v=%b, want v=1", valid4);
        end
        #2;
        rst_n = 1'b0;
        resetModels();
        #1;
        testsRun++;
        if ({valid4, oh4, idx4} !== 7'b0) begin
            testsFailed++;
            $display("[TB] FAIL areset_now: got v=%b oh=%b idx=%0d, want all zero", valid4, oh4, idx4);
        end
        step();
        step();
        rst_n = 1'b1;
        req4 = 4'b1010; ready4 = 1'b1;
        step();
        testsRun++;
        if ({valid4, oh4, idx4} !== {1'b1, 4'b0010, 2'd1}) begin
            testsFailed++;
            $display("[TB] FAIL areset_first: got v=%b oh=%b idx=%0d, want v=1 oh=0010 idx=1", valid4, oh4, idx4);
        end
        step();
        testsRun++;
        if ({valid4, oh4, idx4} !== {1'b1, 4'b1000, 2'd3}) begin
            testsFailed++;
            $display("[TB] FAIL areset_second: got v=%b oh=%b idx=%0d, want v=1 oh=1000 idx=3", valid4, oh4, idx4);
        end
        idle4();
    endtask

    task automatic test_random();
        logic [7:0] e4;
        logic [7:0] e3;
        logic [1:0] ei4;
        logic [1:0] ei3;
        for (int c = 0; c < 400; c++) begin
            req4   = 4'($urandom);
            ready4 = ($urandom_range(0, 3) != 0);
            flush4 = ($urandom_range(0, 19) == 0);
            req3   = 3'($urandom);
            ready3 = ($urandom_range(0, 3) != 0);
            flush3 = ($urandom_range(0, 19) == 0);
            step();
            e4  = ohOf(mV4, mI4);
            e3  = ohOf(mV3, mI3);
            ei4 = 2'(mI4);
            ei3 = 2'(mI3);
            testsRun++;
            if ({valid4, oh4, idx4} !== {mV4, e4[3:0], ei4}) begin
                testsFailed++;
                $display("[TB] FAIL random4[%0d]: got v=%b oh=%b idx=%0d, want v=%b oh=%b idx=%0d",
                         c, valid4, oh4, idx4, mV4, e4[3:0], ei4);
            end
            testsRun++;
            if ({valid3, oh3, idx3} !== {mV3, e3[2:0], ei3}) begin
                testsFailed++;
                $display("[TB] FAIL random3[%0d]: got v=%b oh=%b idx=%0d, want v=%b oh=%b idx=%0d",
                         c, valid3, oh3, idx3, mV3, e3[2:0], ei3);
            end
        end
        flush4 = 1'b0;
        flush3 = 1'b0;
        req3   = 3'b000;
        idle4();
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        rst_n  = 1'b0;
        req4   = 4'b0; flush4 = 1'b0; ready4 = 1'b1;
        req3   = 3'b0; flush3 = 1'b0; ready3 = 1'b1;
        resetModels();
        test_reset();
        test_full_contention();
        test_backpressure();
        test_single_requester();
        test_non_pow2();
        test_flush_hold();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
